// File: rtl/matmul_stream_engine_pkg.sv
// Shared state encoding and elaboration helpers for matmul_stream_engine.
package matmul_stream_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_A   = 3'd1;
  localparam logic [2:0] ST_GET_B   = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;

  // Index width with a floor of one bit so single-entry ranges still get a counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic bit dw_legal(input int dw);
    return (dw == 8) || (dw == 16);
  endfunction

endpackage

// File: rtl/matmul_stream_engine_if.sv
// Byte-stream handshake and status bundle between the UART byte side and the engine.
interface matmul_stream_engine_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;
  logic [3:0] dim;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, err, dim
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, err, dim
  );
endinterface

// File: rtl/matmul_stream_engine_mac.sv
// Single multiply-accumulate unit; MATMUL_SIGNED_EN selects two's-complement operands.
// sum is the accumulator's next value so the caller can capture a finished dot product.
module matmul_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] a_ext_s;
  logic [ACC_W-1:0] b_ext_s;
  logic [ACC_W-1:0] prod_s;
  logic [ACC_W-1:0] acc_r;

  // Extend operands; the low ACC_W product bits are then correct in both arithmetic modes.
  always_comb begin
`ifdef MATMUL_SIGNED_EN
    a_ext_s = {{(ACC_W-DW){a[DW-1]}}, a};
    b_ext_s = {{(ACC_W-DW){b[DW-1]}}, b};
`else
    a_ext_s = {{(ACC_W-DW){1'b0}}, a};
    b_ext_s = {{(ACC_W-DW){1'b0}}, b};
`endif
    prod_s = a_ext_s * b_ext_s;
    if (clr) begin
      sum = prod_s;
    end else begin
      sum = acc_r + prod_s;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en) begin
      acc_r <= sum;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/matmul_stream_engine.sv
// Streaming N x N matrix multiply: size byte, A, B in; C out LSB-first per element.
// Define MATMUL_SIGNED_EN for two's-complement elements with sign-extended results.
module matmul_stream_engine
  import matmul_stream_pkg::*;
#(
  parameter int MAX_N = 4,
  parameter int DW    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  matmul_stream_engine_if.slave bus
);

  localparam int ACC_W     = 2*DW + $clog2(MAX_N);
  localparam int RES_BYTES = (ACC_W + 7) / 8;
  localparam int RW        = RES_BYTES * 8;
  // Illegal widths fall back to single-byte elements.
  localparam int EB        = dw_legal(DW) ? DW/8 : 1;
  localparam int IW        = clog2(MAX_N);
  localparam int AW        = clog2(MAX_N*MAX_N);
  localparam int BW        = clog2(RES_BYTES);

  logic [2:0]     state_r, state_nxt_s;
  logic [3:0]     dim_r;
  logic [IW-1:0]  i_r, j_r, k_r;
  logic           bsel_r;
  logic [7:0]     lo_r;
  logic [BW-1:0]  byte_cnt_r;
  logic [RW-1:0]  sreg_r;
  logic           in_ready_r, out_valid_r, busy_r, err_r;
  logic [DW-1:0]  mat_a_r [MAX_N*MAX_N];
  logic [DW-1:0]  mat_b_r [MAX_N*MAX_N];

  logic           in_fire_s, out_fire_s, size_ok_s, elem_done_s;
  logic           row_end_s, mat_end_s, last_byte_s;
  logic [IW-1:0]  last_s;
  logic [DW-1:0]  elem_s;
  logic [AW-1:0]  wr_addr_s, rd_a_s, rd_b_s;
  logic [ACC_W-1:0] mac_sum_s;
  logic [RW-1:0]  res_ext_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = sreg_r[7:0];
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;
  assign bus.dim       = dim_r;

  // Handshake qualifiers, element assembly and storage addressing.
  always_comb begin
    in_fire_s   = bus.in_valid && in_ready_r;
    out_fire_s  = out_valid_r && bus.out_ready;
    size_ok_s   = (bus.in_data >= 8'd1) && (bus.in_data <= 8'(MAX_N));
    elem_done_s = (EB == 1) || bsel_r;
    last_s      = IW'(dim_r - 4'd1);
    row_end_s   = (j_r == last_s);
    mat_end_s   = row_end_s && (i_r == last_s);
    last_byte_s = (byte_cnt_r == BW'(RES_BYTES - 1));
    if (EB == 1) begin
      elem_s = DW'(bus.in_data);
    end else begin
      elem_s = DW'({bus.in_data, lo_r});
    end
    wr_addr_s = AW'(i_r) * AW'(MAX_N) + AW'(j_r);
    rd_a_s    = AW'(i_r) * AW'(MAX_N) + AW'(k_r);
    rd_b_s    = AW'(k_r) * AW'(MAX_N) + AW'(j_r);
`ifdef MATMUL_SIGNED_EN
    res_ext_s = {{(RW-ACC_W){mac_sum_s[ACC_W-1]}}, mac_sum_s};
`else
    res_ext_s = {{(RW-ACC_W){1'b0}}, mac_sum_s};
`endif
  end

  matmul_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (k_r == {IW{1'b0}}),
    .en    (state_r == ST_COMPUTE),
    .a     (mat_a_r[rd_a_s]),
    .b     (mat_b_r[rd_b_s]),
    .sum   (mac_sum_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_fire_s && size_ok_s) state_nxt_s = ST_GET_A;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_GET_A: begin
        if (in_fire_s && elem_done_s && mat_end_s) state_nxt_s = ST_GET_B;
        else                                      state_nxt_s = ST_GET_A;
      end
      ST_GET_B: begin
        if (in_fire_s && elem_done_s && mat_end_s) state_nxt_s = ST_COMPUTE;
        else                                      state_nxt_s = ST_GET_B;
      end
      ST_COMPUTE: begin
        if (k_r == last_s) state_nxt_s = ST_SEND;
        else               state_nxt_s = ST_COMPUTE;
      end
      ST_SEND: begin
        if (out_fire_s && last_byte_s) state_nxt_s = mat_end_s ? ST_IDLE : ST_COMPUTE;
        else                           state_nxt_s = ST_SEND;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state, counters, result shifter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dim_r       <= 4'd0;
      i_r         <= {IW{1'b0}};
      j_r         <= {IW{1'b0}};
      k_r         <= {IW{1'b0}};
      bsel_r      <= 1'b0;
      lo_r        <= 8'd0;
      byte_cnt_r  <= {BW{1'b0}};
      sreg_r      <= {RW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_GET_A) ||
                     (state_nxt_s == ST_GET_B);
      out_valid_r <= (state_nxt_s == ST_SEND);
      busy_r      <= (state_nxt_s != ST_IDLE);
      err_r       <= (state_r == ST_IDLE) && in_fire_s && !size_ok_s;
      case (state_r)
        ST_IDLE: begin
          if (in_fire_s && size_ok_s) begin
            dim_r  <= bus.in_data[3:0];
            i_r    <= {IW{1'b0}};
            j_r    <= {IW{1'b0}};
            k_r    <= {IW{1'b0}};
            bsel_r <= 1'b0;
          end
        end
        ST_GET_A, ST_GET_B: begin
          if (in_fire_s) begin
            if (elem_done_s) begin
              bsel_r <= 1'b0;
              j_r    <= row_end_s ? {IW{1'b0}} : j_r + 1'b1;
              if (row_end_s) i_r <= mat_end_s ? {IW{1'b0}} : i_r + 1'b1;
            end else begin
              lo_r   <= bus.in_data;
              bsel_r <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (k_r == last_s) begin
            k_r        <= {IW{1'b0}};
            sreg_r     <= res_ext_s;
            byte_cnt_r <= {BW{1'b0}};
          end else begin
            k_r <= k_r + 1'b1;
          end
        end
        ST_SEND: begin
          if (out_fire_s) begin
            if (last_byte_s) begin
              byte_cnt_r <= {BW{1'b0}};
              j_r        <= row_end_s ? {IW{1'b0}} : j_r + 1'b1;
              if (row_end_s) i_r <= mat_end_s ? {IW{1'b0}} : i_r + 1'b1;
            end else begin
              byte_cnt_r <= byte_cnt_r + 1'b1;
              sreg_r     <= {8'd0, sreg_r[RW-1:8]};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Matrix storage has no reset; a job always rewrites every element it reads.
  always_ff @(posedge clk) begin
    if (in_fire_s && elem_done_s && (state_r == ST_GET_A)) mat_a_r[wr_addr_s] <= elem_s;
    if (in_fire_s && elem_done_s && (state_r == ST_GET_B)) mat_b_r[wr_addr_s] <= elem_s;
  end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Self-checking bench for matmul_stream_engine (MAX_N=4, DW=8); honours MATMUL_SIGNED_EN.
module tb_matmul_stream_engine;

  localparam int RES_BYTES = 3;

  logic clk = 1'b0;
  logic rst_n;

  matmul_stream_engine_if bus();

  matmul_stream_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     n;
    longint a[16];
    longint b[16];
    longint c[16];
  } vec_t;

  vec_t   tbl[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     job_n;
  longint job_a[16];
  longint job_b[16];
  longint job_c[16];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n);
    vec_t v;
    v.n = n;
    for (int e = 0; e < 16; e++) begin
      v.a[e] = 0;
      v.b[e] = 0;
      v.c[e] = 0;
    end
    return v;
  endfunction

  function automatic longint elem_val(input longint raw);
`ifdef MATMUL_SIGNED_EN
    return (raw > 127) ? raw - 256 : raw;
`else
    return raw;
`endif
  endfunction

  // Reference: plain dot products over the row-major job arrays.
  task automatic model_job();
    for (int i = 0; i < job_n; i++)
      for (int j = 0; j < job_n; j++) begin
        longint s = 0;
        for (int k = 0; k < job_n; k++)
          s += elem_val(job_a[i*job_n+k]) * elem_val(job_b[k*job_n+j]);
        job_c[i*job_n+j] = s;
      end
  endtask

  task automatic load_vec(input vec_t v);
    job_n = v.n;
    for (int e = 0; e < 16; e++) begin
      job_a[e] = v.a[e];
      job_b[e] = v.b[e];
      job_c[e] = v.c[e];
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(posedge clk); #1;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_job();
    send_byte(8'(job_n));
    for (int e = 0; e < job_n*job_n; e++) send_byte(8'(job_a[e]));
    for (int e = 0; e < job_n*job_n; e++) send_byte(8'(job_b[e]));
  endtask

  // Drives one job and checks latency, every result byte, optional stall and idle return.
  task automatic run_job(input string tag, input int stall_e);
    int        t;
    logic [7:0] held;
    bit        stable;
    send_job();
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_latency"}, t, job_n);
    chk({tag, "_dim"}, bus.dim, job_n);
    for (int e = 0; e < job_n*job_n; e++) begin
      for (int bi = 0; bi < RES_BYTES; bi++) begin
        t = 0;
        while (!bus.out_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (t >= 100) chk({tag, "_out_timeout"}, 0, 1);
        if (e == stall_e && bi == 1) begin
          bus.out_ready = 1'b0;
          held   = bus.out_data;
          stable = 1'b1;
          repeat (10) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== held) stable = 1'b0;
          end
          chk({tag, "_stall_stable"}, stable, 1);
          bus.out_ready = 1'b1;
        end
        chk($sformatf("%s_c%0d_b%0d", tag, e, bi), bus.out_data, (job_c[e] >> (8*bi)) & 255);
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_valid_end"}, bus.out_valid, 0);
    chk({tag, "_ready_end"}, bus.in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_dim"}, bus.dim, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk({tag, "_in_ready_first"}, bus.in_ready, 0);
    @(posedge clk);
    #1 chk({tag, "_in_ready_after"}, bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   exp_dim;
    int   t;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Directed vectors: inputs with hand-computed expected elements.
    v = mk(2);
    v.a[0] = 1; v.a[1] = 2; v.a[2] = 3; v.a[3] = 4;
    v.b[0] = 5; v.b[1] = 6; v.b[2] = 7; v.b[3] = 8;
    v.c[0] = 19; v.c[1] = 22; v.c[2] = 43; v.c[3] = 50;
    tbl.push_back(v);
    v = mk(4);
    for (int e = 0; e < 16; e++) begin
      v.a[e] = 255;
      v.b[e] = 255;
`ifdef MATMUL_SIGNED_EN
      v.c[e] = 4;
`else
      v.c[e] = 260100;
`endif
    end
    tbl.push_back(v);
    v = mk(1); v.a[0] = 7; v.b[0] = 9; v.c[0] = 63;
    tbl.push_back(v);
    v = mk(1); v.a[0] = 2; v.b[0] = 3; v.c[0] = 6;
    tbl.push_back(v);
    v = mk(1); v.a[0] = 255; v.b[0] = 2;
`ifdef MATMUL_SIGNED_EN
    v.c[0] = -2;
`else
    v.c[0] = 510;
`endif
    tbl.push_back(v);

    #12;
    check_reset_outputs("por");
    release_reset("por");

    foreach (tbl[idx]) begin
      load_vec(tbl[idx]);
      run_job($sformatf("vec%0d", idx), -1);
    end

    // Illegal size bytes: single-cycle err, dim untouched, byte consumed.
    exp_dim = tbl[tbl.size()-1].n;
    send_byte(8'h00);
    chk("err0_pulse", bus.err, 1);
    chk("err0_dim", bus.dim, exp_dim);
    @(posedge clk); #1 chk("err0_clear", bus.err, 0);
    send_byte(8'h05);
    chk("err5_pulse", bus.err, 1);
    chk("err5_dim", bus.dim, exp_dim);
    chk("err5_busy", bus.busy, 0);
    @(posedge clk); #1 chk("err5_clear", bus.err, 0);
    load_vec(tbl[2]);
    run_job("after_err", -1);

    // Back-pressure during SEND on a random job.
    job_n = 3;
    for (int e = 0; e < 9; e++) begin
      job_a[e] = $urandom_range(0, 255);
      job_b[e] = $urandom_range(0, 255);
    end
    model_job();
    run_job("stall", 4);

    // Reset while collecting B.
    load_vec(tbl[0]);
    send_byte(8'd2);
    for (int e = 0; e < 4; e++) send_byte(8'(job_a[e]));
    send_byte(8'(job_b[0]));
    send_byte(8'(job_b[1]));
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_getb");
    release_reset("rst_getb");

    // Reset while a result is being presented.
    load_vec(tbl[0]);
    send_job();
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_send_reached", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_send");
    release_reset("rst_send");
    load_vec(tbl[3]);
    run_job("fresh", -1);

    // Randomised jobs against the reference model.
    for (int r = 0; r < 8; r++) begin
      job_n = $urandom_range(1, 4);
      for (int e = 0; e < 16; e++) begin
        job_a[e] = $urandom_range(0, 255);
        job_b[e] = $urandom_range(0, 255);
      end
      if (r == 3) begin
        for (int e = 0; e < 16; e++) begin
          job_a[e] = (e % 2 == 0) ? 128 : 255;
          job_b[e] = 128;
        end
      end
      model_job();
      run_job($sformatf("rand%0d", r), (r == 5) ? job_n*job_n - 1 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
